fetch_queue: RTL and testbench

//   Parametrised instruction-fetch front end for the next-generation KGP-RISC core.

---
 rtl/fetch_queue_if.sv | 57 +++++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory req/ack side and decode valid/ready side.
// Latency: n/a (wires only). Backpressure: imem_ack stalls requests, instr_ready stalls the queue head.
// master = fetch_queue, slave = memory/decode environment.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // instruction memory request channel
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ack;
    logic [XLEN-1:0]  imem_rdata;

    // control from the pipeline
    logic             halt;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;

    // decode hand-off
    logic             instr_ready;
    logic             instr_valid;
    logic [XLEN-1:0]  instruction_out;
    logic [XLEN-1:0]  read_addr_pc;
    logic [CNT_W-1:0] count;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  halt,
        input  redirect,
        input  redirect_pc,
        input  instr_ready,
        output instr_valid,
        output instruction_out,
        output read_addr_pc,
        output count
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output halt,
        output redirect,
        output redirect_pc,
        output instr_ready,
        input  instr_valid,
        input  instruction_out,
        input  read_addr_pc,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, imem req/ack, DEPTH-entry in-order {instr, pc} queue.
// Latency: a fetched word reaches the head one cycle after its transfer (no flow-through).
// Backpressure: imem_req drops when full (no same-cycle bypass); redirect flushes and overrides everything.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [XLEN-1:0]  PC_INC   = XLEN'(PC_STEP);

    logic [XLEN-1:0]  fetch_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;

    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];

    logic req;
    logic push;
    logic pop;
    logic head_vld;

    // Request depends only on registered occupancy, so a pop cannot unblock a full queue this cycle.
    always_comb begin
        req      = reset & ~bus.redirect & ~bus.halt & (count_q < FULL_CNT);
        head_vld = (count_q != '0);
        push     = req & bus.imem_ack;
        pop      = head_vld & bus.instr_ready & ~bus.redirect;
    end

    always_comb begin
        count_nxt = count_q;
        unique case ({push, pop})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + PC_INC;
                wr_ptr   <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_nxt;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    always_comb begin
        bus.imem_req        = req;
        bus.imem_addr       = fetch_pc;
        bus.instr_valid     = head_vld;
        bus.instruction_out = head_vld ? instr_mem[rd_ptr] : '0;
        bus.read_addr_pc    = head_vld ? pc_mem[rd_ptr]    : '0;
        bus.count           = count_q;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected {pc, word} pushed on each stimulated transfer,
// a negedge monitor pops and compares whenever decode accepts the head.
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted transfer at the expected address; leaves inputs at posedge+1 with ack low.
    task automatic xfer(input logic [31:0] a);
        exp_t e;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word_of(a);
        @(negedge clk);
        check("xfer_req", 32'(bus.imem_req), 32'd1);
        check("xfer_addr", bus.imem_addr, a);
        e.pc   = a;
        e.word = word_of(a);
        sb.push_back(e);
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc=%h instr=%h, required no entry",
                         bus.read_addr_pc, bus.instruction_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_pc", bus.read_addr_pc, e.pc);
                check("pop_instr", bus.instruction_out, e.word);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_instr", bus.instruction_out, 32'h0);
        check("rst_rpc", bus.read_addr_pc, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        step();
        reset = 1'b1;

        // fill to full
        for (int i = 0; i < 4; i++) xfer(32'(i * 4));
        bus.imem_ack = 1'b1;
        @(negedge clk);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_req", 32'(bus.imem_req), 32'd0);
        check("full_valid", 32'(bus.instr_valid), 32'd1);
        check("full_rpc", bus.read_addr_pc, 32'h0);
        check("full_instr", bus.instruction_out, word_of(32'h0));
        step();
        bus.imem_ack = 1'b0;

        // drain in order
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_count", 32'(bus.count), 32'(4 - k));
            step();
        end
        @(negedge clk);
        check("drained_valid", 32'(bus.instr_valid), 32'd0);
        check("drained_count", 32'(bus.count), 32'd0);
        check("drained_instr", bus.instruction_out, 32'h0);
        step();
        bus.instr_ready = 1'b0;

        // wait states
        repeat (3) begin
            @(negedge clk);
            check("wait_req", 32'(bus.imem_req), 32'd1);
            check("wait_addr", bus.imem_addr, 32'h10);
            check("wait_count", 32'(bus.count), 32'd0);
            step();
        end
        xfer(32'h10);
        @(negedge clk);
        check("after_wait_addr", bus.imem_addr, 32'h14);
        check("after_wait_count", 32'(bus.count), 32'd1);
        check("after_wait_rpc", bus.read_addr_pc, 32'h10);
        step();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        step();
        bus.instr_ready = 1'b0;

        // redirect beats a same-cycle pop and ack
        xfer(32'h14); xfer(32'h18); xfer(32'h1C); xfer(32'h20);
        @(negedge clk);
        check("pre_redir_count", 32'(bus.count), 32'd4);
        step();
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        bus.imem_ack    = 1'b1;
        @(negedge clk);
        check("redir_req", 32'(bus.imem_req), 32'd0);
        sb.delete();
        step();
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check("redir_count", 32'(bus.count), 32'd0);
        check("redir_valid", 32'(bus.instr_valid), 32'd0);
        check("redir_addr", bus.imem_addr, 32'h100);
        check("redir_req_next", 32'(bus.imem_req), 32'd1);
        step();
        bus.instr_ready = 1'b0;

        // simultaneous push and pop keeps count
        xfer(32'h100);
        bus.instr_ready = 1'b1;
        xfer(32'h104);
        @(negedge clk);
        check("pushpop_count", 32'(bus.count), 32'd1);
        step();
        bus.instr_ready = 1'b0;
        @(negedge clk);
        check("pushpop_drained", 32'(bus.count), 32'd0);

        // PC wrap
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        xfer(32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_rpc", bus.read_addr_pc, 32'hFFFF_FFFC);
        check("wrap_instr", bus.instruction_out, 32'hFFFC_C0DE);
        check("wrap_addr", bus.imem_addr, 32'h0);
        step();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        step();
        bus.instr_ready = 1'b0;

        // halt withdraws a pending request
        bus.halt = 1'b1;
        @(negedge clk);
        check("halt_req", 32'(bus.imem_req), 32'd0);
        check("halt_addr", bus.imem_addr, 32'h0);
        step();
        bus.imem_ack = 1'b1;
        @(negedge clk);
        check("halt_ack_req", 32'(bus.imem_req), 32'd0);
        step();
        bus.imem_ack = 1'b0;
        bus.halt     = 1'b0;
        @(negedge clk);
        check("halt_count", 32'(bus.count), 32'd0);
        check("unhalt_req", 32'(bus.imem_req), 32'd1);
        step();

        // full queue: no same-cycle bypass on pop
        xfer(32'h0); xfer(32'h4); xfer(32'h8); xfer(32'hC);
        bus.instr_ready = 1'b1;
        bus.imem_ack    = 1'b1;
        @(negedge clk);
        check("nobypass_req", 32'(bus.imem_req), 32'd0);
        step();
        xfer(32'h10);
        bus.instr_ready = 1'b0;
        @(negedge clk);
        check("nobypass_count", 32'(bus.count), 32'd3);

        // asynchronous reset between edges with a request pending
        check("pre_rst_req", 32'(bus.imem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.instr_valid), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_addr", bus.imem_addr, 32'h0);
        check("arst_req", 32'(bus.imem_req), 32'd0);
        check("arst_instr", bus.instruction_out, 32'h0);
        sb.delete();
        bus.imem_ack = 1'b1;
        @(negedge clk);
        check("arst_ack_ignored", 32'(bus.count), 32'd0);
        step();
        bus.imem_ack = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("post_rst_count", 32'(bus.count), 32'd0);
        check("post_rst_addr", bus.imem_addr, 32'h0);
        check("post_rst_req", 32'(bus.imem_req), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
